// File: rtl/router_pkg.sv
// Shared definitions for the packet-aware router output FIFO: header field layout and length decode.
package router_pkg;
  localparam int HDR_LEN_LSB = 2;

  // The header flag sits just above the data field of a stored entry.
  function automatic int hdr_flag_bit(input int data_width);
    return data_width;
  endfunction

  function automatic logic [31:0] hdr_len(input logic [31:0] hdr_byte);
    return hdr_byte >> HDR_LEN_LSB;
  endfunction
endpackage

// File: rtl/router_fifo_pkt_tracker.sv
// Remaining-byte counter for the packet being read; pulses pkt_end alongside the parity byte.
module router_fifo_pkt_tracker #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  flush,
  input  logic                  rd_strobe,
  input  logic                  hdr_flag,
  input  logic [DATA_WIDTH-3:0] len,
  output logic                  pkt_end
);
  logic [DATA_WIDTH-2:0] rem;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rem     <= '0;
      pkt_end <= 1'b0;
    end else if (flush) begin
      rem     <= '0;
      pkt_end <= 1'b0;
    end else begin
      pkt_end <= 1'b0;
      if (rd_strobe) begin
        // A header always reloads, abandoning any unfinished packet.
        if (hdr_flag) begin
          rem <= {1'b0, len} + 1'b1;
        end else if (rem != '0) begin
          rem     <= rem - 1'b1;
          pkt_end <= (rem == {{(DATA_WIDTH-2){1'b0}}, 1'b1});
        end
      end
    end
  end
endmodule

// File: rtl/router_fifo_pkt.sv
// Packet-aware output FIFO for one router destination port.
// Optional FIFO_RD_TIMEOUT_EN: flush stored data after TIMEOUT_CYC idle read cycles.
module router_fifo_pkt
  import router_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int DEPTH       = 16,
  parameter int TIMEOUT_CYC = 30
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     soft_reset,
  input  logic                     write_enb,
  input  logic                     lfd_state,
  input  logic [DATA_WIDTH-1:0]    data_in,
  input  logic                     read_enb,
  output logic [DATA_WIDTH-1:0]    data_out,
  output logic                     empty,
  output logic                     full,
  output logic                     pkt_end,
  output logic [$clog2(DEPTH):0]   occupancy
);
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int FLAG_B = hdr_flag_bit(DATA_WIDTH);

  logic [DATA_WIDTH:0] mem [DEPTH];
  logic [ADDR_W:0]     wr_ptr, rd_ptr, wr_nxt, rd_nxt;
  logic                do_wr, do_rd, flush;
  logic [DATA_WIDTH:0] rd_entry;
  logic [31:0]         len_full;

`ifdef FIFO_RD_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] idle_cnt;
  logic             timeout_hit;

  assign timeout_hit = !empty && !read_enb && (idle_cnt == CNT_W'(TIMEOUT_CYC - 1));
  assign flush       = soft_reset | timeout_hit;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                                         idle_cnt <= '0;
    else if (flush || read_enb || empty)                  idle_cnt <= '0;
    else                                                  idle_cnt <= idle_cnt + 1'b1;
  end
`else
  assign flush = soft_reset;
`endif

  assign do_wr    = write_enb && !full && !flush;
  assign do_rd    = read_enb && !empty && !flush;
  assign wr_nxt   = wr_ptr + (ADDR_W+1)'(do_wr);
  assign rd_nxt   = rd_ptr + (ADDR_W+1)'(do_rd);
  assign rd_entry = mem[rd_ptr[ADDR_W-1:0]];
  assign len_full = hdr_len(32'(rd_entry[DATA_WIDTH-1:0]));

  always_ff @(posedge clock) begin
    if (do_wr) mem[wr_ptr[ADDR_W-1:0]] <= {lfd_state, data_in};
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
      empty     <= 1'b1;
      full      <= 1'b0;
      data_out  <= '0;
    end else if (flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
      empty     <= 1'b1;
      full      <= 1'b0;
      data_out  <= '0;
    end else begin
      wr_ptr    <= wr_nxt;
      rd_ptr    <= rd_nxt;
      occupancy <= wr_nxt - rd_nxt;
      empty     <= (wr_nxt == rd_nxt);
      full      <= (wr_nxt[ADDR_W] != rd_nxt[ADDR_W]) &&
                   (wr_nxt[ADDR_W-1:0] == rd_nxt[ADDR_W-1:0]);
      if (do_rd) data_out <= rd_entry[DATA_WIDTH-1:0];
    end
  end

  router_fifo_pkt_tracker #(.DATA_WIDTH(DATA_WIDTH)) u_tracker (
    .clock     (clock),
    .reset_n   (reset_n),
    .flush     (flush),
    .rd_strobe (do_rd),
    .hdr_flag  (rd_entry[FLAG_B]),
    .len       (len_full[DATA_WIDTH-3:0]),
    .pkt_end   (pkt_end)
  );
endmodule

// File: tb/tb_router_fifo_pkt.sv
// Bench for router_fifo_pkt: directed scenarios plus random traffic against a queue-based model.
module tb_router_fifo_pkt;
  logic       clock = 1'b0;
  logic       reset_n, soft_reset, write_enb, lfd_state, read_enb;
  logic [7:0] data_in, data_out;
  logic       empty, full, pkt_end;
  logic [4:0] occupancy;

  int errors = 0;
  int checks = 0;

  logic [8:0] mq[$];
  logic [7:0] m_dout;
  bit         m_pend;
  int         m_rem;

  always #5 clock = ~clock;

  router_fifo_pkt #(.DATA_WIDTH(8), .DEPTH(16), .TIMEOUT_CYC(30)) dut (
    .clock(clock), .reset_n(reset_n), .soft_reset(soft_reset),
    .write_enb(write_enb), .lfd_state(lfd_state), .data_in(data_in),
    .read_enb(read_enb), .data_out(data_out), .empty(empty), .full(full),
    .pkt_end(pkt_end), .occupancy(occupancy)
  );

  task automatic model_clear();
    mq.delete();
    m_dout = 8'h00;
    m_pend = 1'b0;
    m_rem  = 0;
  endtask

  // Drive one cycle, advance the reference model, return #1 after the edge.
  task automatic step(input bit wr, input bit lfd, input logic [7:0] din, input bit rd,
                      input bit sr = 1'b0);
    int sz;
    logic [8:0] e;
    write_enb = wr; lfd_state = lfd; data_in = din; read_enb = rd; soft_reset = sr;
    @(posedge clock);
    sz = mq.size();
    if (sr) begin
      model_clear();
    end else begin
      m_pend = 1'b0;
      if (rd && sz > 0) begin
        e = mq.pop_front();
        m_dout = e[7:0];
        if (e[8]) m_rem = int'(e[7:2]) + 1;
        else if (m_rem > 0) begin
          m_rem--;
          if (m_rem == 0) m_pend = 1'b1;
        end
      end
      if (wr && sz < 16) mq.push_back({lfd, din});
    end
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic test_reset();
    reset_n = 1'b0; soft_reset = 0; write_enb = 0; lfd_state = 0; read_enb = 0; data_in = 0;
    model_clear();
    #12;
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b want 1", empty); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b want 0", full); end
    checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL reset_dout: got %h want 00", data_out); end
    checks++; if (pkt_end !== 1'b0) begin errors++; $display("FAIL reset_pkt_end: got %b want 0", pkt_end); end
    checks++; if (occupancy !== 5'd0) begin errors++; $display("FAIL reset_occ: got %0d want 0", occupancy); end
    reset_n = 1'b1;
  endtask

  task automatic test_packet();
    logic [7:0] pkt [5];
    pkt = '{8'h0C, 8'hA1, 8'hA2, 8'hA3, 8'h5E};
    for (int i = 0; i < 5; i++) step(1'b1, i == 0, pkt[i], 1'b0);
    checks++; if (occupancy !== 5'd5) begin errors++; $display("FAIL pkt_occ: got %0d want 5", occupancy); end
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, 8'h00, 1'b1);
      checks++; if (data_out !== pkt[i]) begin errors++; $display("FAIL pkt_data[%0d]: got %h want %h", i, data_out, pkt[i]); end
      checks++; if (pkt_end !== (i == 4)) begin errors++; $display("FAIL pkt_end[%0d]: got %b want %b", i, pkt_end, i == 4); end
    end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL pkt_empty: got %b want 1", empty); end
    idle();
    checks++; if (pkt_end !== 1'b0) begin errors++; $display("FAIL pkt_end_pulse: got %b want 0", pkt_end); end
  endtask

  task automatic test_full();
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 8'h30 + 8'(i), 1'b0);
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL full_set: got %b want 1", full); end
    checks++; if (occupancy !== 5'd16) begin errors++; $display("FAIL full_occ: got %0d want 16", occupancy); end
    step(1'b1, 1'b0, 8'hEE, 1'b0);
    checks++; if (occupancy !== 5'd16) begin errors++; $display("FAIL full_drop_occ: got %0d want 16", occupancy); end
    step(1'b0, 1'b0, 8'h00, 1'b1);
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL full_clear: got %b want 0", full); end
    checks++; if (occupancy !== 5'd15) begin errors++; $display("FAIL full_occ15: got %0d want 15", occupancy); end
    checks++; if (data_out !== 8'h30) begin errors++; $display("FAIL full_first: got %h want 30", data_out); end
    for (int i = 1; i < 16; i++) begin
      step(1'b0, 1'b0, 8'h00, 1'b1);
      checks++; if (data_out !== 8'h30 + 8'(i)) begin errors++; $display("FAIL full_drain[%0d]: got %h want %h", i, data_out, 8'h30 + 8'(i)); end
    end
    step(1'b0, 1'b0, 8'h00, 1'b1);
    checks++; if (data_out !== 8'h3F) begin errors++; $display("FAIL full_dropped_byte: got %h want 3f", data_out); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL full_empty: got %b want 1", empty); end
  endtask

  task automatic test_wrap();
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 8'h40 + 8'(r*16 + i), 1'b0);
      for (int i = 0; i < 10; i++) begin
        step(1'b0, 1'b0, 8'h00, 1'b1);
        checks++; if (data_out !== 8'h40 + 8'(r*16 + i)) begin errors++; $display("FAIL wrap[%0d][%0d]: got %h want %h", r, i, data_out, 8'h40 + 8'(r*16 + i)); end
      end
    end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL wrap_empty: got %b want 1", empty); end
  endtask

  task automatic test_soft_reset();
    logic [7:0] pkt [5];
    logic [7:0] p2 [3];
    pkt = '{8'h0C, 8'h11, 8'h22, 8'h33, 8'h44};
    p2  = '{8'h04, 8'h99, 8'h66};
    for (int i = 0; i < 5; i++) step(1'b1, i == 0, pkt[i], 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    step(1'b1, 1'b0, 8'h77, 1'b1, 1'b1);
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL sr_empty: got %b want 1", empty); end
    checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL sr_dout: got %h want 00", data_out); end
    checks++; if (occupancy !== 5'd0) begin errors++; $display("FAIL sr_occ: got %0d want 0", occupancy); end
    for (int i = 0; i < 3; i++) step(1'b1, i == 0, p2[i], 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 8'h00, 1'b1);
      checks++; if (data_out !== p2[i]) begin errors++; $display("FAIL sr_pkt_data[%0d]: got %h want %h", i, data_out, p2[i]); end
      checks++; if (pkt_end !== (i == 2)) begin errors++; $display("FAIL sr_pkt_end[%0d]: got %b want %b", i, pkt_end, i == 2); end
    end
  endtask

  task automatic test_async_reset();
    step(1'b1, 1'b0, 8'h77, 1'b0);
    step(1'b1, 1'b0, 8'h78, 1'b0);
    step(1'b1, 1'b0, 8'h79, 1'b1);
    #3 reset_n = 1'b0;
    #1;
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL arst_empty: got %b want 1", empty); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL arst_full: got %b want 0", full); end
    checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL arst_dout: got %h want 00", data_out); end
    #2 reset_n = 1'b1;
    model_clear();
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 8'hC0 + 8'(i), 1'b0);
    step(1'b1, 1'b0, 8'hC4, 1'b1);
    checks++; if (occupancy !== 5'd4) begin errors++; $display("FAIL rw_occ: got %0d want 4", occupancy); end
    checks++; if (data_out !== 8'hC0) begin errors++; $display("FAIL rw_dout: got %h want c0", data_out); end
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 8'h00, 1'b1);
    checks++; if (data_out !== 8'hC4) begin errors++; $display("FAIL rw_last: got %h want c4", data_out); end
  endtask

  task automatic test_random();
    bit wr, lfd, rd, sr;
    logic [7:0] din;
    for (int c = 0; c < 600; c++) begin
      wr  = ($urandom_range(0, 99) < 55);
      rd  = ($urandom_range(0, 99) < 50);
      lfd = ($urandom_range(0, 5) == 0);
      sr  = ($urandom_range(0, 199) == 0);
      din = lfd ? {4'h0, 2'($urandom_range(0, 3)), 2'($urandom)} : 8'($urandom);
      step(wr, lfd, din, rd, sr);
      checks++;
      if (data_out !== m_dout || pkt_end !== m_pend || empty !== (mq.size() == 0) ||
          full !== (mq.size() == 16) || occupancy !== 5'(mq.size())) begin
        errors++;
        $display("FAIL rand[%0d]: got dout=%h end=%b e=%b f=%b occ=%0d want dout=%h end=%b e=%b f=%b occ=%0d",
                 c, data_out, pkt_end, empty, full, occupancy,
                 m_dout, m_pend, mq.size() == 0, mq.size() == 16, mq.size());
      end
    end
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
  endtask

`ifdef FIFO_RD_TIMEOUT_EN
  task automatic test_timeout();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'hD0 + 8'(i), 1'b0);
    for (int i = 0; i < 40; i++) idle();
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL to_flush: got %b want 1", empty); end
    model_clear();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'hE0 + 8'(i), 1'b0);
    for (int i = 0; i < 20; i++) idle();
    step(1'b0, 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 20; i++) idle();
    checks++; if (occupancy !== 5'd2) begin errors++; $display("FAIL to_held: got %0d want 2", occupancy); end
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
  endtask
`endif

  initial begin
    test_reset();
    test_packet();
    test_full();
    test_wrap();
    test_soft_reset();
    test_async_reset();
    test_random();
`ifdef FIFO_RD_TIMEOUT_EN
    test_timeout();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end
endmodule
